// File: rtl/d_cache.sv
// d_cache: direct-mapped write-back write-allocate data cache with an AHB-Lite burst master.
// Victim write-back and line refill are aligned INCR16 bursts; CPU stalls until the request hits.
module d_cache #(
    parameter int CACHE_LINE_WIDTH = 6,
    parameter int TAG_WIDTH = 22
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] dbus_addr,
    input  logic [31:0] dbus_wrdata,
    input  logic [3:0]  dbus_byteenable,
    input  logic        dbus_read,
    input  logic        dbus_write,
    input  logic        dbus_hitwriteback,
    input  logic        dbus_hitinvalidate,
    output logic [31:0] dbus_rddata,
    output logic        dbus_stall,
    output logic [31:0] AHB_haddr,
    output logic        AHB_hwrite,
    output logic [1:0]  AHB_htrans,
    output logic [2:0]  AHB_hburst,
    output logic [2:0]  AHB_hsize,
    output logic [3:0]  AHB_hprot,
    output logic [31:0] AHB_hwdata,
    output logic        AHB_sel,
    output logic        AHB_hready_in,
    input  logic        AHB_hready_out,
    input  logic [31:0] AHB_hrdata,
    input  logic        AHB_hresp
);
    localparam int WW = CACHE_LINE_WIDTH - 2;
    localparam int IW = 32 - TAG_WIDTH - CACHE_LINE_WIDTH;
    localparam int NW = 1 << WW;
    localparam int NL = 1 << IW;

    typedef enum logic [1:0] {IDLE, WB, FILL} state_t;
    state_t state, state_nxt;

    logic [NL-1:0]        valid, dirty;
    logic [TAG_WIDTH-1:0] tags [NL];
    logic [31:0]          mem [NL][NW];
    logic [WW:0]          beat;
    logic                 dph;
    logic [WW-1:0]        didx;

    logic [IW-1:0]        idx;
    logic [WW-1:0]        word;
    logic [TAG_WIDTH-1:0] req_tag;
    logic hit, maint, is_inv, is_wr, access, any_req, addr_act, last;
    logic unused_ok;

    assign idx      = dbus_addr[31-TAG_WIDTH -: IW];
    assign word     = dbus_addr[CACHE_LINE_WIDTH-1:2];
    assign req_tag  = dbus_addr[31 -: TAG_WIDTH];
    assign hit      = valid[idx] && tags[idx] == req_tag;
    assign is_inv   = dbus_hitinvalidate;
    assign maint    = dbus_hitinvalidate || dbus_hitwriteback;
    assign is_wr    = !maint && dbus_write;
    assign access   = dbus_write || dbus_read;
    assign any_req  = maint || access;
    assign addr_act = state != IDLE && !beat[WW];
    assign last     = state != IDLE && dph && didx == '1 && AHB_hready_out;
    assign unused_ok = ^{AHB_hresp, dbus_addr[1:0]};

    always_comb begin
        state_nxt  = state;
        dbus_stall = 1'b0;
        case (state)
            IDLE: begin
                if (maint) begin
                    dbus_stall = hit && dirty[idx];
                    state_nxt  = dbus_stall ? WB : IDLE;
                end else if (access && !hit) begin
                    dbus_stall = 1'b1;
                    state_nxt  = valid[idx] && dirty[idx] ? WB : FILL;
                end
            end
            WB: begin
                dbus_stall = any_req;
                state_nxt  = last ? (maint ? IDLE : FILL) : WB;
            end
            FILL: begin
                dbus_stall = any_req;
                state_nxt  = last ? IDLE : FILL;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
            beat  <= '0;
            dph   <= 1'b0;
            didx  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                beat <= '0;
                dph  <= 1'b0;
                if (is_inv && hit && !dirty[idx]) valid[idx] <= 1'b0;
                if (is_wr && hit) dirty[idx] <= 1'b1;
            end else if (AHB_hready_out) begin
                // address of beat i+1 overlaps the data phase of beat i
                beat <= last ? '0 : beat + (WW+1)'(addr_act);
                dph  <= addr_act;
                if (addr_act) didx <= beat[WW-1:0];
                if (last && state == WB && maint) begin
                    dirty[idx] <= 1'b0;
                    if (is_inv) valid[idx] <= 1'b0;
                end
                if (last && state == FILL) begin
                    valid[idx] <= 1'b1;
                    dirty[idx] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && is_wr && hit)
            for (int b = 0; b < 4; b++)
                if (dbus_byteenable[b]) mem[idx][word][8*b +: 8] <= dbus_wrdata[8*b +: 8];
        if (state == FILL && dph && AHB_hready_out) mem[idx][didx] <= AHB_hrdata;
        if (last && state == FILL) tags[idx] <= req_tag;
    end

    assign dbus_rddata   = mem[idx][word];
    assign AHB_haddr     = {state == WB ? tags[idx] : req_tag, idx, beat[WW-1:0], 2'b00};
    assign AHB_htrans    = addr_act ? (beat == '0 ? 2'b10 : 2'b11) : 2'b00;
    assign AHB_hwrite    = state == WB;
    assign AHB_hburst    = state == IDLE ? 3'b000 : 3'b111;
    assign AHB_hsize     = 3'b010;
    assign AHB_hprot     = 4'b0011;
    assign AHB_hwdata    = mem[idx][didx];
    assign AHB_sel       = addr_act || dph;
    assign AHB_hready_in = 1'b1;
endmodule

// File: tb/tb_d_cache.sv
// tb_d_cache: directed stimulus against a flat CPU-view memory model and an AHB slave memory.
// Loads, write-back data and burst address sequencing are checked every cycle they are meaningful.
module tb_d_cache;
    localparam logic [3:0] RD = 4'b0001, WR = 4'b0010, HWB = 4'b0100, HINV = 4'b1000;

    logic        clk = 1'b0, nrst;
    logic [31:0] dbus_addr, dbus_wrdata, dbus_rddata;
    logic [3:0]  dbus_byteenable;
    logic        dbus_read, dbus_write, dbus_hitwriteback, dbus_hitinvalidate, dbus_stall;
    logic [31:0] AHB_haddr, AHB_hwdata, AHB_hrdata;
    logic        AHB_hwrite, AHB_sel, AHB_hready_in, hready;
    logic [1:0]  AHB_htrans;
    logic [2:0]  AHB_hburst, AHB_hsize;
    logic [3:0]  AHB_hprot;

    always #5 clk = ~clk;

    d_cache dut (
        .clk(clk), .nrst(nrst),
        .dbus_addr(dbus_addr), .dbus_wrdata(dbus_wrdata), .dbus_byteenable(dbus_byteenable),
        .dbus_read(dbus_read), .dbus_write(dbus_write),
        .dbus_hitwriteback(dbus_hitwriteback), .dbus_hitinvalidate(dbus_hitinvalidate),
        .dbus_rddata(dbus_rddata), .dbus_stall(dbus_stall),
        .AHB_haddr(AHB_haddr), .AHB_hwrite(AHB_hwrite), .AHB_htrans(AHB_htrans),
        .AHB_hburst(AHB_hburst), .AHB_hsize(AHB_hsize), .AHB_hprot(AHB_hprot),
        .AHB_hwdata(AHB_hwdata), .AHB_sel(AHB_sel), .AHB_hready_in(AHB_hready_in),
        .AHB_hready_out(hready), .AHB_hrdata(AHB_hrdata), .AHB_hresp(1'b0)
    );

    int passed = 0, total = 0;
    int n_wb = 0, n_rd = 0;
    logic [31:0] wb_start, rd_start, wb0;
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] smem [logic [29:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A5A5A;
    endfunction
    function automatic logic [31:0] rm(input logic [31:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : dflt(a);
    endfunction
    function automatic logic [31:0] sm(input logic [31:0] a);
        return smem.exists(a[31:2]) ? smem[a[31:2]] : dflt(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // AHB slave: decide at negedge on settled signals, commit at the clock edge
    logic        s_pend = 1'b0, s_wr = 1'b0, n_pend = 1'b0, n_wr = 1'b0;
    logic [31:0] s_addr = '0, n_addr = '0, s_rdata = '0, n_rdata = '0;
    assign AHB_hrdata = s_rdata;

    always @(negedge clk) begin
        n_pend = s_pend; n_addr = s_addr; n_wr = s_wr; n_rdata = s_rdata;
        if (nrst && hready) begin
            if (s_pend && s_wr) begin
                chk("wb_data", AHB_hwdata, rm(s_addr));
                smem[s_addr[31:2]] = AHB_hwdata;
                if (s_addr[5:0] == 6'd0) wb0 = AHB_hwdata;
            end
            if (AHB_htrans == 2'b10) begin
                if (AHB_hwrite) begin n_wb++; wb_start = AHB_haddr; end
                else begin n_rd++; rd_start = AHB_haddr; end
            end
            n_pend = AHB_htrans[1]; n_addr = AHB_haddr; n_wr = AHB_hwrite; n_rdata = sm(AHB_haddr);
        end
    end

    always @(posedge clk or negedge nrst) begin
        if (!nrst) s_pend <= 1'b0;
        else begin
            s_pend <= n_pend; s_addr <= n_addr; s_wr <= n_wr; s_rdata <= n_rdata;
        end
    end

    // compare process: CPU-visible coherence and burst sequencing
    logic        p_act = 1'b0, p_rdy = 1'b1;
    logic [31:0] p_addr = '0;
    logic [1:0]  p_trans = '0;
    always @(negedge clk) begin
        if (!nrst) p_act = 1'b0;
        else begin
            if (!dbus_stall && !dbus_hitinvalidate && !dbus_hitwriteback) begin
                if (dbus_write) begin
                    logic [31:0] w;
                    w = rm(dbus_addr);
                    for (int b = 0; b < 4; b++)
                        if (dbus_byteenable[b]) w[8*b +: 8] = dbus_wrdata[8*b +: 8];
                    ref_mem[dbus_addr[31:2]] = w;
                end else if (dbus_read) chk("load", dbus_rddata, rm(dbus_addr));
            end
            if (AHB_htrans != 2'b00)
                chk("ahb_ctl", 32'({AHB_hburst, AHB_hsize, AHB_sel, AHB_hprot}), 32'({3'b111, 3'b010, 1'b1, 4'b0011}));
            if (p_act && !p_rdy) begin
                chk("hold_addr", AHB_haddr, p_addr);
                chk("hold_trans", 32'(AHB_htrans), 32'(p_trans));
            end else if (AHB_htrans == 2'b10) chk("nonseq_align", 32'(AHB_haddr[5:0]), 32'd0);
            else if (AHB_htrans == 2'b11) chk("seq_addr", AHB_haddr, p_act ? p_addr + 32'd4 : 32'hFFFFFFFF);
            p_act = AHB_htrans != 2'b00; p_rdy = hready; p_addr = AHB_haddr; p_trans = AHB_htrans;
        end
    end

    task automatic op(input logic [3:0] kind, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, output logic [31:0] rd, output int st);
        {dbus_hitinvalidate, dbus_hitwriteback, dbus_write, dbus_read} = kind;
        dbus_addr = a; dbus_wrdata = d; dbus_byteenable = be; st = 0;
        @(negedge clk);
        while (dbus_stall && st < 300) begin
            st++;
            @(negedge clk);
        end
        if (dbus_stall) chk("timeout", 32'd1, 32'd0);
        rd = dbus_rddata;
        @(posedge clk); #1;
        {dbus_hitinvalidate, dbus_hitwriteback, dbus_write, dbus_read} = 4'b0000;
    endtask

    initial begin
        logic [31:0] rd;
        int st, wbs, rds;
        nrst = 1'b0; hready = 1'b1;
        dbus_addr = '0; dbus_wrdata = '0; dbus_byteenable = '0;
        {dbus_hitinvalidate, dbus_hitwriteback, dbus_write, dbus_read} = 4'b0000;
        repeat (2) @(posedge clk); #1;
        chk("rst_htrans", 32'(AHB_htrans), 32'd0);
        chk("rst_sel_hwrite_stall", 32'({AHB_sel, AHB_hwrite, dbus_stall}), 32'd0);
        chk("rst_const", 32'({AHB_hburst, AHB_hsize, AHB_hprot, AHB_hready_in}), 32'({3'b000, 3'b010, 4'b0011, 1'b1}));
        nrst = 1'b1;
        @(posedge clk); #1;

        op(WR, 32'h80000100, 32'hDEADBEEF, 4'hF, rd, st);
        chk("clean_miss_lat", 32'(st), 32'd18);
        chk("first_fill_addr", rd_start, 32'h80000100);
        chk("no_wb_on_clean", 32'(n_wb), 32'd0);
        op(RD, 32'h80000100, 0, 4'hF, rd, st);
        chk("rd_after_fill", rd, 32'hDEADBEEF);
        chk("rd_hit_lat", 32'(st), 32'd0);

        op(WR, 32'h80000100, 32'h00000055, 4'b0001, rd, st);
        chk("byte_write_lat", 32'(st), 32'd0);
        op(RD, 32'h80000100, 0, 4'hF, rd, st);
        chk("byte_merge", rd, 32'hDEADBE55);

        op(RD, 32'h80000500, 0, 4'hF, rd, st);
        chk("dirty_miss_lat", 32'(st), 32'd35);
        chk("wb_start", wb_start, 32'h80000100);
        chk("wb_beat0", wb0, 32'hDEADBE55);
        chk("refill_addr", rd_start, 32'h80000500);
        chk("refill_data", rd, 32'hDA5A5F5A);

        op(WR, 32'h80000504, 32'h12345678, 4'hF, rd, st);
        wbs = n_wb;
        op(HINV, 32'h80000500, 0, 4'hF, rd, st);
        chk("hinv_dirty_lat", 32'(st), 32'd18);
        chk("hinv_wb_count", 32'(n_wb), 32'(wbs + 1));
        chk("hinv_wb_start", wb_start, 32'h80000500);
        op(RD, 32'h80000504, 0, 4'hF, rd, st);
        chk("reread_miss_lat", 32'(st), 32'd18);
        chk("reread_data", rd, 32'h12345678);

        wbs = n_wb; rds = n_rd;
        op(HINV, 32'h80000504, 0, 4'hF, rd, st);
        chk("hinv_clean_lat", 32'(st), 32'd0);
        op(HINV, 32'h80000504, 0, 4'hF, rd, st);
        chk("hinv_miss_lat", 32'(st), 32'd0);
        op(HWB, 32'h80000504, 0, 4'hF, rd, st);
        chk("hwb_miss_lat", 32'(st), 32'd0);
        chk("maint_no_traffic", 32'(n_wb + n_rd), 32'(wbs + rds));

        fork
            op(RD, 32'h80000900, 0, 4'hF, rd, st);
            begin
                repeat (8) @(posedge clk); #1;
                hready = 1'b0;
                repeat (3) @(posedge clk); #1;
                hready = 1'b1;
            end
        join
        chk("stalled_fill_lat", 32'(st), 32'd21);
        chk("stalled_fill_w0", rd, 32'hDA5A535A);
        for (int i = 1; i < 16; i++) op(RD, 32'h80000900 + 32'(4 * i), 0, 4'hF, rd, st);

        op(WR, 32'h80000904, 32'hCAFEF00D, 4'hF, rd, st);
        wbs = n_wb;
        op(HWB, 32'h80000904, 0, 4'hF, rd, st);
        chk("hwb_dirty_lat", 32'(st), 32'd18);
        chk("hwb_wb_start", wb_start, 32'h80000900);
        chk("hwb_wb_count", 32'(n_wb), 32'(wbs + 1));
        op(RD, 32'h80000904, 0, 4'hF, rd, st);
        chk("hwb_keeps_valid", 32'(st), 32'd0);
        op(HWB, 32'h80000904, 0, 4'hF, rd, st);
        chk("hwb_clean_lat", 32'(st), 32'd0);

        dbus_addr = 32'h80000D40; dbus_read = 1'b1;
        repeat (6) @(posedge clk); #1;
        dbus_read = 1'b0;
        nrst = 1'b0;
        ref_mem = smem;
        #1;
        chk("rst_mid_fill_htrans", 32'(AHB_htrans), 32'd0);
        chk("rst_mid_fill_sel", 32'(AHB_sel), 32'd0);
        repeat (2) @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        op(RD, 32'h80000904, 0, 4'hF, rd, st);
        chk("post_rst_miss_lat", 32'(st), 32'd18);
        chk("post_rst_data", rd, 32'hCAFEF00D);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
